// File: rtl/dig6_disp_arbiter.sv
// Shares a 6-digit 7-seg display among N_SRC requesters. Grants and digit data change only on frame boundaries.
// Optional DIG6_ARB_PREEMPT_EN: source 0 takes the display at the next frame boundary regardless of hold.
module dig6_disp_arbiter #(
  parameter int N_SRC       = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_FRAMES = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SRC-1:0]    req,
  input  logic [N_SRC*24-1:0] src_dig,
  output logic [N_SRC-1:0]    gnt,
  output logic [N_SRC-1:0]    done,
  output logic                scan_tick,
  output logic [2:0]          scan_pos,
  output logic [23:0]         disp_dig,
  output logic                busy
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int OW = $clog2(N_SRC);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic {ST_IDLE, ST_OWN} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       presc_q;
  logic [2:0]          pos_q;
  logic [OW-1:0]       owner_q, owner_d;
  logic [N_SRC-1:0]    gnt_q, gnt_d;
  logic [N_SRC-1:0]    done_q, done_d;
  logic [23:0]         disp_q, disp_d;
  logic [HW-1:0]       hold_q, hold_d;

  logic                fb;
  logic                rel;
  logic [OW:0]         pick;
  logic [N_SRC-1:0]    own_oh;
  logic [N_SRC-1:0]    others;

  // Returns {found, index} of the first set bit searching upward from (from+1) mod N_SRC.
  function automatic logic [OW:0] rr_pick(input logic [N_SRC-1:0] mask, input logic [OW-1:0] from);
    logic [OW:0]   r;
    logic [OW-1:0] jj;
    int            j;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      j  = (int'(from) + 1 + i) % N_SRC;
      jj = OW'(j);
      if (mask[jj]) r = {1'b1, jj};
    end
    return r;
  endfunction

  assign scan_tick = (presc_q == PW'(SCAN_DIV - 1));
  assign fb        = scan_tick && (pos_q == 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pos_q   <= '0;
    end else begin
      presc_q <= scan_tick ? '0 : presc_q + PW'(1);
      if (scan_tick) pos_q <= (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OW'(N_SRC - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      disp_q  <= 24'hFFFFFF;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    disp_d  = disp_q;
    hold_d  = hold_q;
    rel     = 1'b0;
    pick    = '0;
    own_oh  = {{(N_SRC-1){1'b0}}, 1'b1} << owner_q;
    others  = req & ~own_oh;

    if (fb) begin
      case (state_q)
        ST_IDLE: begin
          pick = rr_pick(req, owner_q);
        end
        ST_OWN: begin
          rel = !req[owner_q] || ((int'(hold_q) + 1 >= HOLD_FRAMES) && (|others));
`ifdef DIG6_ARB_PREEMPT_EN
          if (req[0] && (owner_q != '0)) rel = 1'b1;
`endif
          if (rel) begin
            done_d = own_oh;
            // The outgoing owner is only a candidate when nobody else is asking.
            pick   = rr_pick((|others) ? others : req, owner_q);
`ifdef DIG6_ARB_PREEMPT_EN
            if (req[0] && (owner_q != '0)) pick = {1'b1, {OW{1'b0}}};
`endif
          end else begin
            disp_d = src_dig[int'(owner_q)*24 +: 24];
            if (int'(hold_q) < HOLD_FRAMES) hold_d = hold_q + HW'(1);
          end
        end
        default: ;
      endcase

      if (pick[OW]) begin
        state_d = ST_OWN;
        owner_d = pick[OW-1:0];
        gnt_d   = {{(N_SRC-1){1'b0}}, 1'b1} << pick[OW-1:0];
        disp_d  = src_dig[int'(pick[OW-1:0])*24 +: 24];
        hold_d  = '0;
      end else if (rel) begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        disp_d  = 24'hFFFFFF;
        hold_d  = '0;
      end
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign scan_pos = pos_q;
  assign disp_dig = disp_q;
  assign busy     = |gnt_q;

endmodule

// File: tb/tb_dig6_disp_arbiter.sv
// Directed bench for dig6_disp_arbiter with N_SRC=4, SCAN_DIV=4, HOLD_FRAMES=2 (24-clock frames).
module tb_dig6_disp_arbiter;

  localparam int N_SRC = 4;

  logic               clk;
  logic               rst_n;
  logic [N_SRC-1:0]   req;
  logic [N_SRC*24-1:0] src_dig;
  logic [N_SRC-1:0]   gnt;
  logic [N_SRC-1:0]   done;
  logic               scan_tick;
  logic [2:0]         scan_pos;
  logic [23:0]        disp_dig;
  logic               busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  dig6_disp_arbiter #(.N_SRC(4), .SCAN_DIV(4), .HOLD_FRAMES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .src_dig   (src_dig),
    .gnt       (gnt),
    .done      (done),
    .scan_tick (scan_tick),
    .scan_pos  (scan_pos),
    .disp_dig  (disp_dig),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Edge counter restarts at each reset release; edge 24*m ends a frame boundary.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    src_dig = {24'hD3D3D3, 24'h123456, 24'hB1B1B1, 24'hA0A0A0};
    repeat (3) step();

    check("rst_gnt",  gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", scan_tick, 0);
    check("rst_pos",  scan_pos, 0);
    check("rst_disp", disp_dig, 24'hFFFFFF);

    rst_n = 1'b1;
    cyc   = 0;
    check("tick0", scan_tick, 0);
    check("pos0",  scan_pos, 0);
    for (int k = 0; k < 100; k++) begin
      step();
      check("idle_tick", scan_tick, (cyc % 4) == 3);
      check("idle_pos",  scan_pos, (cyc / 4) % 6);
      check("idle_gnt",  gnt, 0);
      check("idle_disp", disp_dig, 24'hFFFFFF);
    end

    req = 4'b0100;
    go_to(119);
    check("pre_fb_gnt",  gnt, 0);
    check("pre_fb_disp", disp_dig, 24'hFFFFFF);
    go_to(120);
    check("g2_gnt",  gnt, 4'b0100);
    check("g2_disp", disp_dig, 24'h123456);
    check("g2_busy", busy, 1);
    check("g2_done", done, 0);
    go_to(125);
    src_dig[2*24 +: 24] = 24'h654321;
    go_to(143);
    check("hold_disp_stable", disp_dig, 24'h123456);
    go_to(144);
    check("reload_disp", disp_dig, 24'h654321);
    check("keep_done",   done, 0);
    check("keep_gnt",    gnt, 4'b0100);
    go_to(150);
    req = 4'b0000;
    go_to(168);
    check("drop2_done", done, 4'b0100);
    check("drop2_gnt",  gnt, 0);
    check("drop2_disp", disp_dig, 24'hFFFFFF);
    check("drop2_busy", busy, 0);
    go_to(169);
    check("drop2_done_clr", done, 0);

    req = 4'b0011;
    go_to(192);
    check("rr_g0",      gnt, 4'b0001);
    check("rr_g0_disp", disp_dig, 24'hA0A0A0);
    check("rr_g0_done", done, 0);
    go_to(216);
    check("rr_hold0_gnt",  gnt, 4'b0001);
    check("rr_hold0_done", done, 0);
    go_to(240);
    check("rr_sw1_done", done, 4'b0001);
    check("rr_sw1_gnt",  gnt, 4'b0010);
    check("rr_sw1_disp", disp_dig, 24'hB1B1B1);
    go_to(241);
    check("rr_sw1_done_clr", done, 0);
    check("rr_sw1_gnt_keep", gnt, 4'b0010);
    go_to(264);
    check("rr_hold1_gnt", gnt, 4'b0010);
    check("rr_hold1_done", done, 0);
    go_to(288);
    check("rr_back0_done", done, 4'b0010);
    check("rr_back0_gnt",  gnt, 4'b0001);
    check("rr_back0_disp", disp_dig, 24'hA0A0A0);

    go_to(312);
    check("t4_hold_gnt", gnt, 4'b0001);
    go_to(336);
    check("t4_sw1_done", done, 4'b0001);
    check("t4_sw1_gnt",  gnt, 4'b0010);
    go_to(340);
    req = 4'b0000;
    go_to(359);
    check("t4_pre_gnt", gnt, 4'b0010);
    go_to(360);
    check("t4_rel_done", done, 4'b0010);
    check("t4_rel_gnt",  gnt, 0);
    check("t4_rel_disp", disp_dig, 24'hFFFFFF);
    check("t4_rel_busy", busy, 0);

    go_to(362);
    req = 4'b0100;
    go_to(384);
    check("t5_gnt",  gnt, 4'b0100);
    check("t5_disp", disp_dig, 24'h654321);
    go_to(390);
    check("t5_pos_before", scan_pos, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_gnt",  gnt, 0);
    check("arst_pos",  scan_pos, 0);
    check("arst_disp", disp_dig, 24'hFFFFFF);
    check("arst_busy", busy, 0);
    check("arst_tick", scan_tick, 0);
    step();
    step();
    check("arst_hold_gnt", gnt, 0);
    rst_n = 1'b1;
    cyc   = 0;
    check("rel_tick0", scan_tick, 0);
    step();
    check("rel_tick1", scan_tick, 0);
    step();
    check("rel_tick2", scan_tick, 0);
    step();
    check("rel_tick3", scan_tick, 1);
    step();
    check("rel_tick4", scan_tick, 0);
    check("rel_pos4",  scan_pos, 1);
    go_to(23);
    check("rel_pre_gnt", gnt, 0);
    go_to(24);
    check("rel_gnt",  gnt, 4'b0100);
    check("rel_disp", disp_dig, 24'h654321);

    go_to(28);
    req = 4'b0101;
    go_to(48);
`ifdef DIG6_ARB_PREEMPT_EN
    check("pre_done", done, 4'b0100);
    check("pre_gnt",  gnt, 4'b0001);
    check("pre_disp", disp_dig, 24'hA0A0A0);
`else
    check("nopre_gnt",  gnt, 4'b0100);
    check("nopre_done", done, 0);
    check("nopre_disp", disp_dig, 24'h654321);
`endif
    go_to(72);
`ifdef DIG6_ARB_PREEMPT_EN
    check("pre_keep_gnt",  gnt, 4'b0001);
    check("pre_keep_done", done, 0);
`else
    check("nopre_sw_done", done, 4'b0100);
    check("nopre_sw_gnt",  gnt, 4'b0001);
    check("nopre_sw_disp", disp_dig, 24'hA0A0A0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dig6_disp_arbiter.md
# dig6_disp_arbiter

Shares the 6-digit 7-segment display between up to `N_SRC` requesters and sets the display's scan cadence. The block generates the digit-scan tick and digit position for the 6-digit scan driver. It grants the display round-robin, with a minimum hold time per owner. Ownership and digit data change only on frame boundaries, so a frame never mixes digits from two owners.

## Interface
Parameters:
- `N_SRC`, 4 — number of requesters (2..8)
- `SCAN_DIV`, 50000 — clk cycles per digit step (≥2)
- `HOLD_FRAMES`, 200 — minimum frames an owner keeps the display (≥1)

Ports:
- `clk` in 1 — single clock
- `rst_n` in 1 — asynchronous, active-low reset
- `req` in N_SRC — level request per source
- `src_dig` in N_SRC*24 — source i, digit k (k=0 leftmost) at bits [i*24+k*4 +: 4]
- `gnt` out N_SRC — one-hot current owner, or all-zero when idle
- `done` out N_SRC — 1-cycle pulse on the owner's bit when it loses the grant
- `scan_tick` out 1 — 1-cycle pulse every SCAN_DIV clocks; the driver advances one digit per pulse
- `scan_pos` out 3 — digit currently scanned, 0..5
- `disp_dig` out 24 — digits to display, same packing as one `src_dig` slice
- `busy` out 1 — `|gnt`

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. `scan_tick` is high while the prescaler equals SCAN_DIV-1.
- `scan_pos` increments on `scan_tick` and wraps 5→0.
- Frame boundary (FB): a cycle where `scan_tick`=1 and `scan_pos`=5. All arbitration happens only on FB.
- States:
  - IDLE: no owner.
  - OWN: owner o holds the display; frame counter `hold_cnt` is active.
- IDLE, on FB:
  - Any `req` set: grant the first set bit searching from (last owner+1) mod N_SRC. After reset, last owner = N_SRC-1, so the search starts at 0.
  - Load `disp_dig` from that source's slice, set `hold_cnt`=0, go to OWN.
- OWN, on each FB, `hold_cnt` saturates at HOLD_FRAMES. The decision uses the pre-increment value:
  - `req[o]`=0: release.
  - `hold_cnt`+1 ≥ HOLD_FRAMES and some other `req[j]`=1: release.
  - Otherwise: keep the grant and reload `disp_dig` from `src_dig[o]`.
- Release on FB:
  - Pulse `done[o]`.
  - In the same FB, grant the next requester round-robin from o+1, excluding o unless o is the only requester. Load its digits and set `hold_cnt`=0.
  - No requester: go to IDLE and set `disp_dig`=24'hFFFFFF (blank code F on every digit).
- `req` changes between FBs have no effect until the next FB. `disp_dig` is stable for a whole frame.

## Timing
- Reset values:
  - `gnt`=0, `done`=0, `busy`=0
  - `scan_tick`=0, `scan_pos`=0, prescaler=0
  - `disp_dig`=24'hFFFFFF, `hold_cnt`=0
  - State IDLE
- Asynchronous assert clears all registers immediately. Deassert is synchronised by the caller.
- Reset mid-frame or mid-hold: on release, the first `scan_tick` comes SCAN_DIV clocks after the first active edge.
- Registered outputs (`gnt`, `done`, `disp_dig`, `busy`) update on the clock edge that ends the FB cycle. That is the same edge on which `scan_pos` becomes 0.
- Latency from `req` to `gnt` is at most one frame (6*SCAN_DIV clocks) plus one clock.
- Only one `done` bit is ever high, for exactly one cycle. `done` and the new `gnt` appear on the same edge.
- `done` does not pulse on a retained grant.

## Configuration
- `DIG6_ARB_PREEMPT_EN`, defined: source 0 is urgent.
  - On any FB where `req[0]`=1 and the owner is not 0, the owner is released regardless of `hold_cnt`.
  - Source 0 is granted, and its own hold rules apply afterwards.
- Undefined: pure round-robin with minimum hold. Source 0 has no special treatment.

## Test plan
Parameters for all scenarios: N_SRC=4, SCAN_DIV=4, HOLD_FRAMES=2 (frame = 24 clocks).
- Reset, then no requests for 100 clocks → `scan_tick` every 4th clock, `scan_pos` cycles 0..5, `gnt`=0, `disp_dig`=FFFFFF.
- `req`=4'b0100 mid-frame, `src_dig[2]`=24'h123456 → at next FB edge `gnt`=0100, `disp_dig`=123456. Change the slice to 654321 mid-frame → `disp_dig` changes only at the following FB.
- `req`=4'b0011 held → source 0 owns for 2 frames, then `done`=0001 and `gnt`=0010 on one edge; 2 frames later the grant returns to 0.
- Owner 1 drops `req` during frame 0 of its hold → released at the next FB with a `done[1]` pulse, then IDLE with blank digits.
- Assert `rst_n`=0 during OWN mid-frame → `gnt`, `scan_pos`, `disp_dig` reset immediately. After release, the first tick comes 4 clocks later.
- With `DIG6_ARB_PREEMPT_EN`: source 2 owns, `req[0]` rises in its first frame → grant moves to 0 at the next FB. Without the macro, the move waits for HOLD_FRAMES.
